codec_cfg_sequencer: RTL and testbench

Power-up configuration controller for the WM8731 audio codec that feeds the I2S sample path. It walks a fixed table of ten register writes, sends each as a 3-byte I2C write through an open-drain two-wire port, and reports completion or failure. The sample datapath stays muted by system software until `done` is high.

---
 rtl/codec_cfg_pkg.sv | 44 ++++
 rtl/codec_i2c_byte_tx.sv | 110 +++++++++++
 rtl/codec_cfg_sequencer.sv | 166 ++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared types, constants and the WM8731 power-up register table
// for the codec configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_GAP,
        S_FINISH
    } cfg_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_BYTE,
        TX_STOP
    } tx_op_e;

    localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;
    localparam int CFG_ENTRIES = 10;

    // {reg[6:0], data[8:0]}; entry 8 = slave/16-bit/left-justified, 9 = ACTIVE
    localparam logic [15:0] CFG_TABLE [CFG_ENTRIES] = '{
        16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1201
    };

    function automatic logic [7:0] cfg_byte(
        input logic [3:0] idx,
        input logic [1:0] pos
    );
        logic [15:0] v;
        v = CFG_TABLE[idx];
        unique case (pos)
            2'd0:    cfg_byte = {CODEC_I2C_ADDR, 1'b0};
            2'd1:    cfg_byte = v[15:8];
            default: cfg_byte = v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/codec_i2c_byte_tx.sv
// I2C bit engine: one START, STOP or 8-bit+ACK byte per go pulse,
// built on a CLK_DIV quarter-bit tick.
module codec_i2c_byte_tx
    import codec_cfg_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_go,
    input  tx_op_e     i_op,
    input  logic [7:0] i_byte,
    input  logic       i_sda_in,
    output logic       o_scl,
    output logic       o_sda_oe,
    output logic       o_bit_done,
    output logic       o_ack_ok
);

    localparam int CW = $clog2(CLK_DIV + 1);

    tx_op_e        r_op;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;
    logic [3:0]    r_bit;
    logic [7:0]    r_sh;
    logic          w_tick;

    assign w_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= TX_IDLE;
            r_cnt      <= '0;
            r_q        <= '0;
            r_bit      <= '0;
            r_sh       <= '0;
            o_scl      <= 1'b1;
            o_sda_oe   <= 1'b0;
            o_bit_done <= 1'b0;
            o_ack_ok   <= 1'b0;
        end else begin
            o_bit_done <= 1'b0;
            if (r_op == TX_IDLE) begin
                if (i_go) begin
                    r_op  <= i_op;
                    r_cnt <= '0;
                    r_q   <= '0;
                    r_bit <= '0;
                    r_sh  <= i_byte;
                    unique case (i_op)
                        TX_START: o_sda_oe <= 1'b1;
                        TX_BYTE: begin
                            o_scl    <= 1'b0;
                            o_sda_oe <= ~i_byte[7];
                        end
                        TX_STOP: begin
                            o_scl    <= 1'b0;
                            o_sda_oe <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                if (w_tick) begin
                    r_q <= r_q + 2'd1;
                    unique case (r_op)
                        TX_START: begin
                            if (r_q == 2'd0) begin
                                o_scl <= 1'b0;
                            end else begin
                                o_bit_done <= 1'b1;
                                r_op       <= TX_IDLE;
                            end
                        end
                        TX_BYTE: begin
                            if (r_q == 2'd1) o_scl <= 1'b1;
                            // q3 tick: sample, then drop SCL and shift in one edge
                            if (r_q == 2'd3) begin
                                o_scl <= 1'b0;
                                if (r_bit == 4'd8) begin
                                    o_ack_ok   <= ~i_sda_in;
                                    o_bit_done <= 1'b1;
                                    r_op       <= TX_IDLE;
                                end else begin
                                    r_bit    <= r_bit + 4'd1;
                                    o_sda_oe <= (r_bit == 4'd7) ? 1'b0 : ~r_sh[6];
                                    r_sh     <= {r_sh[6:0], 1'b0};
                                end
                            end
                        end
                        TX_STOP: begin
                            if (r_q == 2'd0) begin
                                o_scl <= 1'b1;
                            end else if (r_q == 2'd1) begin
                                o_sda_oe <= 1'b0;
                            end else begin
                                o_bit_done <= 1'b1;
                                r_op       <= TX_IDLE;
                            end
                        end
                        default: r_op <= TX_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// WM8731 power-up sequencer: writes the register table over I2C.
// Define CODEC_CFG_RETRY_EN to retry NACKed entries up to MAX_RETRY times.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 125,
    parameter int GAP_CYCLES = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index,
    output logic       i2c_scl,
    output logic       i2c_sda_oe,
    input  logic       i2c_sda_in
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    cfg_state_e    r_state;
    tx_op_e        r_op;
    logic          r_go;
    logic [7:0]    r_byte;
    logic          r_boot;
    logic [3:0]    r_idx;
    logic [1:0]    r_bpos;
    logic          r_nack;
    logic [GW-1:0] r_gap;
    logic          w_tx_done;
    logic          w_ack_ok;
    logic          w_can_retry;

`ifdef CODEC_CFG_RETRY_EN
    logic [1:0] r_retry;
    assign w_can_retry = (r_retry < 2'(MAX_RETRY));
`else
    logic w_unused_retry;
    assign w_unused_retry = (MAX_RETRY > 0);
    assign w_can_retry    = 1'b0;
`endif

    codec_i2c_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk        (clk),
        .reset      (reset),
        .i_go       (r_go),
        .i_op       (r_op),
        .i_byte     (r_byte),
        .i_sda_in   (i2c_sda_in),
        .o_scl      (i2c_scl),
        .o_sda_oe   (i2c_sda_oe),
        .o_bit_done (w_tx_done),
        .o_ack_ok   (w_ack_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= TX_IDLE;
            r_go      <= 1'b0;
            r_byte    <= '0;
            r_boot    <= 1'b1;
            r_idx     <= '0;
            r_bpos    <= '0;
            r_nack    <= 1'b0;
            r_gap     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
`ifdef CODEC_CFG_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_go <= 1'b0;
            unique case (r_state)
                S_IDLE, S_FINISH: begin
                    r_state <= S_IDLE;
                    if (r_boot || start) begin
                        r_boot    <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        r_idx     <= '0;
                        r_nack    <= 1'b0;
                        r_go      <= 1'b1;
                        r_op      <= TX_START;
                        r_state   <= S_START;
`ifdef CODEC_CFG_RETRY_EN
                        r_retry   <= '0;
`endif
                    end
                end
                S_START: begin
                    if (w_tx_done) begin
                        r_bpos  <= '0;
                        r_state <= S_BYTE;
                    end
                end
                S_BYTE: begin
                    r_go    <= 1'b1;
                    r_op    <= TX_BYTE;
                    r_byte  <= cfg_byte(r_idx, r_bpos);
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (w_tx_done) begin
                        if (!w_ack_ok) r_nack <= 1'b1;
                        if (!w_ack_ok || r_bpos == 2'd2) begin
                            r_go    <= 1'b1;
                            r_op    <= TX_STOP;
                            r_state <= S_STOP;
                        end else begin
                            r_bpos  <= r_bpos + 2'd1;
                            r_state <= S_BYTE;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tx_done) begin
                        if (!r_nack) begin
`ifdef CODEC_CFG_RETRY_EN
                            r_retry <= '0;
`endif
                            if (r_idx == 4'(CFG_ENTRIES - 1)) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_FINISH;
                            end else begin
                                r_idx   <= r_idx + 4'd1;
                                r_state <= S_GAP;
                            end
                        end else if (w_can_retry) begin
`ifdef CODEC_CFG_RETRY_EN
                            r_retry <= r_retry + 2'd1;
`endif
                            r_nack  <= 1'b0;
                            r_state <= S_GAP;
                        end else begin
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_index <= r_idx;
                            r_state   <= S_FINISH;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_gap   <= '0;
                        r_go    <= 1'b1;
                        r_op    <= TX_START;
                        r_state <= S_START;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with an I2C slave decoder,
// NACK injection and SCL/SDA protocol monitor.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;

    localparam int CD  = 4;
    localparam int GAP = 8;
    localparam int LIM = 8000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [3:0] err_index;
    logic       i2c_scl, i2c_sda_oe, i2c_sda_in;
    logic       slave_low = 1'b0;

    assign i2c_sda_in = ~(i2c_sda_oe | slave_low);

    always #5 clk = ~clk;

    codec_cfg_sequencer #(
        .CLK_DIV(CD), .GAP_CYCLES(GAP), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .i2c_scl(i2c_scl), .i2c_sda_oe(i2c_sda_oe), .i2c_sda_in(i2c_sda_in)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] tbl [10] = '{
        16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1201
    };

    logic [7:0] tx_b [64][3];
    int         tx_nb [64];
    int         tx_cnt = 0, stop_cnt = 0;
    int         bitcnt = 0, pos = 0, hi_len = 0;
    int         nack_mode = 0;
    logic       nack_used = 1'b0;
    logic       in_tx = 1'b0, hi_chg = 1'b1;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, ln;
    logic [7:0] sh = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tx(input int t, input int e);
        chk($sformatf("tx%0d_nb", t), tx_nb[t], 3);
        chk($sformatf("tx%0d_b0", t), tx_b[t][0], 8'h34);
        chk($sformatf("tx%0d_b1", t), tx_b[t][1], tbl[e][15:8]);
        chk($sformatf("tx%0d_b2", t), tx_b[t][2], tbl[e][7:0]);
    endtask

    // Slave decoder: ACKs every byte except the injected NACK on entry 3
    always @(negedge clk) begin
        ln = ~(i2c_sda_oe | slave_low);
        if (reset) begin
            bitcnt = 0; pos = 0; in_tx = 0; hi_chg = 1; hi_len = 0;
            slave_low = 0; tx_cnt = 0; stop_cnt = 0;
        end else begin
            if (prev_scl && i2c_scl && (ln != prev_sda)) begin
                hi_chg = 1'b1;
                if (!ln) begin
                    in_tx = 1; bitcnt = 0; pos = 0;
                end else begin
                    if (tx_cnt < 64) tx_nb[tx_cnt] = pos;
                    tx_cnt++; stop_cnt++; in_tx = 0;
                end
            end
            if (!prev_scl && i2c_scl) begin
                hi_len = 0; hi_chg = 0;
                if (bitcnt < 8) sh = {sh[6:0], ln};
                bitcnt++;
            end
            if (prev_scl && !i2c_scl) begin
                if (in_tx && !hi_chg) chk("scl_high", hi_len, 2 * CD);
                if (bitcnt == 8) begin
                    if (tx_cnt < 64 && pos < 3) tx_b[tx_cnt][pos] = sh;
                    slave_low = 1'b1;
                    if (pos == 1 && sh == 8'h04 &&
                        (nack_mode == 1 || (nack_mode == 2 && !nack_used))) begin
                        slave_low = 1'b0;
                        nack_used = 1'b1;
                    end
                    pos++;
                end else if (bitcnt == 9) begin
                    slave_low = 1'b0;
                    bitcnt = 0;
                end
            end
            if (i2c_scl) hi_len++;
        end
        prev_scl = i2c_scl;
        prev_sda = ~(i2c_sda_oe | slave_low);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", (n < LIM), 1);
    endtask

    task automatic wait_stops(input int k);
        int n = 0;
        while (stop_cnt < k && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("stop_timeout", (n < LIM), 1);
    endtask

    task automatic clear_log();
        tx_cnt = 0;
        stop_cnt = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_scl", i2c_scl, 1);
        chk("rst_sda_oe", i2c_sda_oe, 0);

        // automatic run, with an ignored start mid-run
        reset = 1'b0;
        wait_stops(3);
        pulse_start();
        chk("mid_busy", busy, 1);
        wait_end();
        chk("clean_done", done, 1);
        chk("clean_error", error, 0);
        chk("clean_busy", busy, 0);
        chk("clean_tx_cnt", tx_cnt, 10);
        chk("clean_stops", stop_cnt, 10);
        for (int e = 0; e < 10; e++) chk_tx(e, e);

        // start after done replays the table
        clear_log();
        pulse_start();
        chk("replay_done_clr", done, 0);
        chk("replay_busy", busy, 1);
        wait_end();
        chk("replay_done", done, 1);
        chk("replay_tx_cnt", tx_cnt, 10);
        chk_tx(0, 0);
        chk_tx(9, 9);

        // persistent NACK on byte 1 of entry 3
        clear_log();
        nack_mode = 1;
        pulse_start();
        wait_end();
        chk("nack_error", error, 1);
        chk("nack_done", done, 0);
        chk("nack_busy", busy, 0);
        chk("nack_err_index", err_index, 3);
`ifdef CODEC_CFG_RETRY_EN
        chk("nack_tx_cnt", tx_cnt, 7);
        chk("nack_stops", stop_cnt, 7);
        chk("nack_last_nb", tx_nb[6], 2);
`else
        chk("nack_tx_cnt", tx_cnt, 4);
        chk("nack_stops", stop_cnt, 4);
        chk("nack_last_nb", tx_nb[3], 2);
`endif
        chk("nack_last_b1", tx_b[3][1], 8'h04);

        // single NACK on entry 3
        clear_log();
        nack_mode = 2;
        nack_used = 1'b0;
        pulse_start();
        wait_end();
`ifdef CODEC_CFG_RETRY_EN
        chk("once_done", done, 1);
        chk("once_error", error, 0);
        chk("once_tx_cnt", tx_cnt, 11);
        chk("once_nb3", tx_nb[3], 2);
        chk_tx(4, 3);
        chk_tx(10, 9);
`else
        chk("once_done", done, 0);
        chk("once_error", error, 1);
        chk("once_err_index", err_index, 3);
        chk("once_tx_cnt", tx_cnt, 4);
`endif

        // reset during bit 5 of entry 6
        clear_log();
        nack_mode = 0;
        pulse_start();
        n = 0;
        while (!(stop_cnt == 6 && pos == 1 && bitcnt == 5) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("rst6_reach", (n < LIM), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst6_scl", i2c_scl, 1);
        chk("rst6_sda_oe", i2c_sda_oe, 0);
        chk("rst6_busy", busy, 0);
        chk("rst6_done", done, 0);
        chk("rst6_error", error, 0);
        chk("rst6_err_index", err_index, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_stops(1);
        chk_tx(0, 0);
        wait_end();
        chk("rst6_final_done", done, 1);
        chk("rst6_tx_cnt", tx_cnt, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
